writeback_register_file: RTL and testbench

Writeback stage and architectural register file for the pipelined MIPS core; it consumes the MEM/WB pipeline outputs. It selects the writeback value (ALU result, load data, or return address for `jal`) and commits it to a 32×32 register file. It serves the decode stage's two combinational read ports with same-cycle write bypass, and exposes the committed write for forwarding logic. A commit counter supports debug and verification.

---
 rtl/writeback_register_file.sv | 83 ++++++++
 tb/tb_writeback_register_file.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_register_file.sv
// Writeback stage and 32x32 architectural register file for the pipelined MIPS core.
// Selects the writeback source, commits it, and serves two read ports that see a write in its own cycle.
module writeback_register_file #(
  parameter logic [31:0] SP_RESET = 32'h7FFF_EFFC,
  parameter logic [31:0] GP_RESET = 32'h1000_8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemToReg,
  input  logic        Jal,
  input  logic        RegWrite,
  input  logic [4:0]  rt,
  input  logic [31:0] ReadData,
  input  logic [31:0] ALUResult,
  input  logic [31:0] PC_PlusFour,
  input  logic [4:0]  ReadReg1,
  input  logic [4:0]  ReadReg2,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic        WriteEnable_WB,
  output logic [4:0]  WriteReg_WB,
  output logic [31:0] WriteData_WB,
  output logic        [31:0] CommitCount
);

  localparam logic [4:0] REG_RA = 5'd31;
  localparam logic [4:0] REG_SP = 5'd29;
  localparam logic [4:0] REG_GP = 5'd28;

  logic [31:0] regs_q [32];
  logic [31:0] commit_count_q;
  logic [31:0] commit_count_d;

  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_en;

  // Jal overrides both the destination and the data source.
  always_comb begin
    wb_reg  = rt;
    wb_data = MemToReg ? ReadData : ALUResult;
    if (Jal) begin
      wb_reg  = REG_RA;
      wb_data = PC_PlusFour;
    end
    wb_en = (RegWrite | Jal) & (wb_reg != 5'd0) & ~reset;
  end

  assign WriteEnable_WB = wb_en;
  assign WriteReg_WB    = wb_reg;
  assign WriteData_WB   = wb_data;

  assign commit_count_d = commit_count_q + 32'd1;
  assign CommitCount    = commit_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        if (i == int'(REG_GP))      regs_q[i] <= GP_RESET;
        else if (i == int'(REG_SP)) regs_q[i] <= SP_RESET;
        else                        regs_q[i] <= 32'h0;
      end
      commit_count_q <= 32'h0;
    end else if (wb_en) begin
      regs_q[wb_reg] <= wb_data;
      commit_count_q <= commit_count_d;
    end
  end

  // r0 reads as zero even though wb_en can never target it.
  always_comb begin
    ReadData1 = regs_q[ReadReg1];
    if (wb_en && (ReadReg1 == wb_reg)) ReadData1 = wb_data;
    if (ReadReg1 == 5'd0) ReadData1 = 32'h0;
  end

  always_comb begin
    ReadData2 = regs_q[ReadReg2];
    if (wb_en && (ReadReg2 == wb_reg)) ReadData2 = wb_data;
    if (ReadReg2 == 5'd0) ReadData2 = 32'h0;
  end

endmodule

// File: tb/tb_writeback_register_file.sv
// Directed self-checking bench for writeback_register_file.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.
module tb_writeback_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemToReg, Jal, RegWrite;
  logic [4:0]  rt, ReadReg1, ReadReg2;
  logic [31:0] ReadData, ALUResult, PC_PlusFour;
  logic [31:0] ReadData1, ReadData2, WriteData_WB, CommitCount;
  logic        WriteEnable_WB;
  logic [4:0]  WriteReg_WB;

  int checks = 0;
  int failures = 0;

  writeback_register_file dut (
    .clk(clk), .reset(reset), .MemToReg(MemToReg), .Jal(Jal), .RegWrite(RegWrite),
    .rt(rt), .ReadData(ReadData), .ALUResult(ALUResult), .PC_PlusFour(PC_PlusFour),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteEnable_WB(WriteEnable_WB), .WriteReg_WB(WriteReg_WB), .WriteData_WB(WriteData_WB),
    .CommitCount(CommitCount)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    MemToReg = 0; Jal = 0; RegWrite = 0; rt = 0;
    ReadData = 0; ALUResult = 0; PC_PlusFour = 0;
  endtask

  task automatic next_drive();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; idle();
    RegWrite = 1; rt = 5'd3; ALUResult = 32'h55;
    @(negedge clk); #1;
    checks++;
    if (WriteEnable_WB !== 1'b0) begin
      failures++; $display("FAIL reset_we: got %0b want 0", WriteEnable_WB);
    end
    next_drive();
    reset = 0; idle();
    ReadReg1 = 5'd0; ReadReg2 = 5'd28; #1;
    checks++;
    if (ReadData1 !== 32'h0) begin failures++; $display("FAIL reset_r0: got %h want 0", ReadData1); end
    checks++;
    if (ReadData2 !== 32'h1000_8000) begin failures++; $display("FAIL reset_r28: got %h want 10008000", ReadData2); end
    ReadReg1 = 5'd29; ReadReg2 = 5'd31; #1;
    checks++;
    if (ReadData1 !== 32'h7FFF_EFFC) begin failures++; $display("FAIL reset_r29: got %h want 7fffeffc", ReadData1); end
    checks++;
    if (ReadData2 !== 32'h0) begin failures++; $display("FAIL reset_r31: got %h want 0", ReadData2); end
    ReadReg1 = 5'd3; #1;
    checks++;
    if (ReadData1 !== 32'h0) begin failures++; $display("FAIL reset_r3_lost: got %h want 0", ReadData1); end
    checks++;
    if (CommitCount !== 32'h0) begin failures++; $display("FAIL reset_count: got %h want 0", CommitCount); end
  endtask

  task automatic test_alu_bypass();
    RegWrite = 1; rt = 5'd8; MemToReg = 0; ALUResult = 32'hAB; ReadData = 32'h77;
    ReadReg1 = 5'd8; ReadReg2 = 5'd9; #1;
    checks++;
    if (ReadData1 !== 32'hAB) begin failures++; $display("FAIL alu_bypass: got %h want ab", ReadData1); end
    checks++;
    if (ReadData2 !== 32'h0) begin failures++; $display("FAIL alu_bypass_other_port: got %h want 0", ReadData2); end
    checks++;
    if (WriteEnable_WB !== 1'b1 || WriteReg_WB !== 5'd8) begin
      failures++; $display("FAIL alu_wb_ctrl: got we=%0b reg=%0d want we=1 reg=8", WriteEnable_WB, WriteReg_WB);
    end
    next_drive();
    idle(); #1;
    checks++;
    if (ReadData1 !== 32'hAB) begin failures++; $display("FAIL alu_array: got %h want ab", ReadData1); end
    checks++;
    if (CommitCount !== 32'd1) begin failures++; $display("FAIL alu_count: got %0d want 1", CommitCount); end
  endtask

  task automatic test_load();
    RegWrite = 1; MemToReg = 1; ReadData = 32'hDEAD_BEEF; ALUResult = 32'h1234; rt = 5'd9; #1;
    checks++;
    if (WriteData_WB !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_wbdata: got %h want deadbeef", WriteData_WB); end
    next_drive();
    idle(); ReadReg2 = 5'd9; #1;
    checks++;
    if (ReadData2 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_r9: got %h want deadbeef", ReadData2); end
    checks++;
    if (CommitCount !== 32'd2) begin failures++; $display("FAIL load_count: got %0d want 2", CommitCount); end
  endtask

  task automatic test_jal();
    Jal = 1; RegWrite = 0; MemToReg = 1; rt = 5'd5; PC_PlusFour = 32'h0040_0010;
    ReadData = 32'h9999; ALUResult = 32'h8888; #1;
    checks++;
    if (WriteReg_WB !== 5'd31) begin failures++; $display("FAIL jal_reg: got %0d want 31", WriteReg_WB); end
    checks++;
    if (WriteData_WB !== 32'h0040_0010) begin failures++; $display("FAIL jal_data: got %h want 00400010", WriteData_WB); end
    next_drive();
    idle(); ReadReg1 = 5'd31; ReadReg2 = 5'd5; #1;
    checks++;
    if (ReadData1 !== 32'h0040_0010) begin failures++; $display("FAIL jal_r31: got %h want 00400010", ReadData1); end
    checks++;
    if (ReadData2 !== 32'h0) begin failures++; $display("FAIL jal_r5: got %h want 0", ReadData2); end
    checks++;
    if (CommitCount !== 32'd3) begin failures++; $display("FAIL jal_count: got %0d want 3", CommitCount); end
  endtask

  task automatic test_r0_write();
    RegWrite = 1; rt = 5'd0; ALUResult = 32'hFFFF_FFFF; ReadReg1 = 5'd0; ReadReg2 = 5'd0; #1;
    checks++;
    if (WriteEnable_WB !== 1'b0) begin failures++; $display("FAIL r0_we: got %0b want 0", WriteEnable_WB); end
    checks++;
    if (ReadData1 !== 32'h0) begin failures++; $display("FAIL r0_bypass: got %h want 0", ReadData1); end
    next_drive();
    idle(); #1;
    checks++;
    if (ReadData2 !== 32'h0) begin failures++; $display("FAIL r0_array: got %h want 0", ReadData2); end
    checks++;
    if (CommitCount !== 32'd3) begin failures++; $display("FAIL r0_count: got %0d want 3", CommitCount); end
  endtask

  task automatic test_dual_bypass();
    RegWrite = 1; rt = 5'd7; ALUResult = 32'hCAFE_F00D; ReadReg1 = 5'd7; ReadReg2 = 5'd7; #1;
    checks++;
    if (ReadData1 !== 32'hCAFE_F00D || ReadData2 !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL dual_bypass: got %h/%h want cafef00d/cafef00d", ReadData1, ReadData2);
    end
    next_drive();
    idle(); ReadReg1 = 5'd8; #1;
    checks++;
    if (ReadData2 !== 32'hCAFE_F00D || ReadData1 !== 32'hAB) begin
      failures++; $display("FAIL dual_array: got r7=%h r8=%h want cafef00d/ab", ReadData2, ReadData1);
    end
    checks++;
    if (CommitCount !== 32'd4) begin failures++; $display("FAIL dual_count: got %0d want 4", CommitCount); end
  endtask

  task automatic test_reset_collision();
    reset = 1; RegWrite = 1; rt = 5'd10; ALUResult = 32'h1111_2222;
    next_drive();
    reset = 0; idle(); ReadReg1 = 5'd10; ReadReg2 = 5'd7; #1;
    checks++;
    if (ReadData1 !== 32'h0) begin failures++; $display("FAIL collide_r10: got %h want 0", ReadData1); end
    checks++;
    if (ReadData2 !== 32'h0) begin failures++; $display("FAIL collide_r7_cleared: got %h want 0", ReadData2); end
    checks++;
    if (CommitCount !== 32'h0) begin failures++; $display("FAIL collide_count: got %h want 0", CommitCount); end
  endtask

  task automatic test_wrap();
    force dut.commit_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.commit_count_q;
    #1;
    checks++;
    if (CommitCount !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_preload: got %h want ffffffff", CommitCount); end
    RegWrite = 1; rt = 5'd11; ALUResult = 32'h11;
    next_drive();
    #1;
    checks++;
    if (CommitCount !== 32'h0) begin failures++; $display("FAIL wrap_zero: got %h want 0", CommitCount); end
    rt = 5'd12; ALUResult = 32'h12;
    next_drive();
    idle(); ReadReg1 = 5'd11; ReadReg2 = 5'd12; #1;
    checks++;
    if (CommitCount !== 32'h1) begin failures++; $display("FAIL wrap_one: got %h want 1", CommitCount); end
    checks++;
    if (ReadData1 !== 32'h11 || ReadData2 !== 32'h12) begin
      failures++; $display("FAIL wrap_data: got %h/%h want 11/12", ReadData1, ReadData2);
    end
  endtask

  initial begin
    reset = 1; idle(); ReadReg1 = 0; ReadReg2 = 0;
    @(negedge clk);
    test_reset();
    test_alu_bypass();
    test_load();
    test_jal();
    test_r0_write();
    test_dual_bypass();
    test_reset_collision();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
